// File: rtl/array_pkg.sv
// Shared types and default geometry for the array stream reader.
// Optional build macro used by this slice: ARRAY_READER_COL_MAJOR_EN.
package array_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ROWS   = 4;
   localparam int DEF_COLS   = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

endpackage

// File: rtl/array_index_ctr.sv
// Wrapping row/column index counter with a final-element flag.
// Build macro: ARRAY_READER_COL_MAJOR_EN selects column-major order (default row-major).
module array_index_ctr #(
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      advance,
   output logic [$clog2(ROWS)-1:0]   row,
   output logic [$clog2(COLS)-1:0]   col,
   output logic                      last
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

   logic row_at_max;
   logic col_at_max;

   assign row_at_max = (row == ROW_MAX);
   assign col_at_max = (col == COL_MAX);

   // The final element is always [ROWS-1][COLS-1], whichever order is built.
   assign last = row_at_max && col_at_max;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
`ifdef ARRAY_READER_COL_MAJOR_EN
         if (row_at_max) begin
            row <= '0;
            col <= col_at_max ? '0 : col + 1'b1;
         end else begin
            row <= row + 1'b1;
         end
`else
         if (col_at_max) begin
            col <= '0;
            row <= row_at_max ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
`endif
      end
   end

endmodule

// File: rtl/array_stream_reader.sv
// Captures a 2-D array in one cycle and streams its elements out one per transfer.
// Build macro: ARRAY_READER_COL_MAJOR_EN switches readout to column-major order.
module array_stream_reader
   import array_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ROWS   = DEF_ROWS,
   parameter int COLS   = DEF_COLS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [DATA_W-1:0]         in_array [ROWS-1:0][COLS-1:0],
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [$clog2(ROWS)-1:0]   out_row,
   output logic [$clog2(COLS)-1:0]   out_col,
   output logic                      out_last
);

   logic [DATA_W-1:0] mem [ROWS-1:0][COLS-1:0];

   state_e state;
   state_e state_next;

   logic load_fire;
   logic xfer;
   logic ctr_clear;
   logic ctr_advance;
   logic at_last;

   // Flush wins over everything except reset, including a load offered in the same cycle.
   assign load_fire   = load_valid && (state == IDLE) && !flush;
   assign xfer        = out_valid && out_ready;
   assign ctr_advance = xfer && !flush;
   assign ctr_clear   = flush || load_fire;

   assign load_ready = (state == IDLE);
   assign out_valid  = (state == STREAM);
   assign out_last   = out_valid && at_last;
   assign out_data   = out_valid ? mem[out_row][out_col] : '0;

   array_index_ctr #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_index_ctr (
      .clk     (clk),
      .rst     (rst),
      .clear   (ctr_clear),
      .advance (ctr_advance),
      .row     (out_row),
      .col     (out_col),
      .last    (at_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (load_fire) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (flush) begin
               state_next = IDLE;
            end else if (xfer && at_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Storage only changes on reset or an accepted load, so a stream is never disturbed.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (load_fire) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               mem[r][c] <= in_array[r][c];
            end
         end
      end
   end

endmodule
